// File: rtl/uart_rx_framer_if.sv
// Receive-side bus of the UART framer: tick/line inputs plus byte handshake and status.
// Latency: none, wires only.
// Backpressure: dataValid/dataAck handshake; an unacked byte is overwritten and overrun is flagged.
interface uart_rx_framer_if #(
    parameter int DATA_BITS = 8
);
    logic                 sampleTick;
    logic                 serialIn;
    logic [DATA_BITS-1:0] dataOut;
    logic                 dataValid;
    logic                 dataAck;
    logic                 framingErr;
    logic                 overrun;
    logic                 busy;

    // Stimulus/consumer side drives the line, the tick and the ack.
    modport master (
        output sampleTick, serialIn, dataAck,
        input  dataOut, dataValid, framingErr, overrun, busy
    );

    // Framer side.
    modport slave (
        input  sampleTick, serialIn, dataAck,
        output dataOut, dataValid, framingErr, overrun, busy
    );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronise line, find start bit, sample mid-bit, assemble LSB-first, check stop.
// Latency: OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) ticks after start detection, plus SYNC_STAGES clks.
// Backpressure: none upstream; an unacked byte is overwritten on delivery and overrun is set.
module uart_rx_framer #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_rx_framer_if.slave rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   ovr_q;
    logic                   busy_q;

    assign rxs           = sync_q[SYNC_STAGES-1];
    assign rx.dataOut    = data_q;
    assign rx.dataValid  = valid_q;
    assign rx.framingErr = ferr_q;
    assign rx.overrun    = ovr_q;
    assign rx.busy       = busy_q;

    // Line synchroniser; preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx.serialIn};
        end
    end

    // Frame FSM with registered outputs; delivery assignments come last so a new byte beats a same-clk ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (valid_q && rx.dataAck) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            if (rx.sampleTick) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            if (rxs) begin
                                // Glitch, not a start bit.
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                            bit_idx  <= bit_idx + 1'b1;
                            if (bit_idx == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            state    <= IDLE;
                            tick_cnt <= '0;
                            busy_q   <= 1'b0;
                            data_q   <= shreg;
                            valid_q  <= 1'b1;
                            ferr_q   <= ~rxs;
                            if (valid_q && !rx.dataAck) begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
